// File: rtl/adxl345_pkg.sv
// Shared constants for the ADXL345 SPI responder: register map addresses,
// register reset values, field widths and the transfer FSM state encoding.
package adxl345_pkg;

    localparam int unsigned ADDR_W    = 6;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned AXIS_W    = 16;
    localparam int unsigned BIT_CNT_W = 3;
    localparam int unsigned SNAP_W    = 3 * AXIS_W;

    localparam logic [ADDR_W-1:0] ADDR_DEVID       = 6'h00;
    localparam logic [ADDR_W-1:0] ADDR_BW_RATE     = 6'h2C;
    localparam logic [ADDR_W-1:0] ADDR_POWER_CTL   = 6'h2D;
    localparam logic [ADDR_W-1:0] ADDR_DATA_FORMAT = 6'h31;
    localparam logic [ADDR_W-1:0] ADDR_DATAX0      = 6'h32;
    localparam logic [ADDR_W-1:0] ADDR_DATAX1      = 6'h33;
    localparam logic [ADDR_W-1:0] ADDR_DATAY0      = 6'h34;
    localparam logic [ADDR_W-1:0] ADDR_DATAY1      = 6'h35;
    localparam logic [ADDR_W-1:0] ADDR_DATAZ0      = 6'h36;
    localparam logic [ADDR_W-1:0] ADDR_DATAZ1      = 6'h37;

    localparam logic [DATA_W-1:0] RST_BW_RATE     = 8'h0A;
    localparam logic [DATA_W-1:0] RST_POWER_CTL   = 8'h00;
    localparam logic [DATA_W-1:0] RST_DATA_FORMAT = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CMD   = 2'd1,
        ST_RDATA = 2'd2,
        ST_WDATA = 2'd3
    } spi_state_e;

    // True for the only registers the master may change.
    function automatic logic is_writable(input logic [ADDR_W-1:0] a);
        return (a == ADDR_BW_RATE) || (a == ADDR_POWER_CTL) || (a == ADDR_DATA_FORMAT);
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous SPI pin with edge pulses.
// Ports:
//   clk, rst  system clock, synchronous active-high reset
//   din       asynchronous input pin
//   level     synchronized level (last synchronizer flop)
//   rise_c    one-cycle pulse when the synchronized level goes 0->1
//   fall_c    one-cycle pulse when the synchronized level goes 1->0
module spi_sync_edge #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise_c,
    output logic fall_c
);

    logic [STAGES-1:0] chain;
    logic              prev;

    // Shift chain plus one extra flop holding the previous synchronized level.
    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= {STAGES{RST_VAL}};
            prev  <= RST_VAL;
        end else begin
            chain <= {chain[STAGES-2:0], din};
            prev  <= chain[STAGES-1];
        end
    end

    assign level  = chain[STAGES-1];
    assign rise_c = chain[STAGES-1] & ~prev;
    assign fall_c = ~chain[STAGES-1] & prev;

endmodule

// File: rtl/adxl345_spi_responder.sv
// SPI mode-3 responder that mimics an ADXL345 register map so sensor
// consumers can run without a real accelerometer.
// Ports:
//   i_clk, i_rst                       system clock, synchronous active-high reset
//   i_CS, i_SPC, i_SDI                 SPI bus from the master (asynchronous)
//   o_SDO, o_SDO_oe                    SPI data back to the master and its drive enable
//   i_ax, i_ay, i_az                   axis samples, snapshotted at each CS fall
//   o_bw_rate, o_power_ctl, o_data_format  writable registers 0x2C/0x2D/0x31
//   o_wr_strobe, o_wr_addr, o_wr_data  pulse and details of each committed write
module adxl345_spi_responder
    import adxl345_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  DEVID_VAL   = 8'hE5
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_CS,
    input  logic                i_SPC,
    input  logic                i_SDI,
    output logic                o_SDO,
    output logic                o_SDO_oe,
    input  logic [AXIS_W-1:0]   i_ax,
    input  logic [AXIS_W-1:0]   i_ay,
    input  logic [AXIS_W-1:0]   i_az,
    output logic [DATA_W-1:0]   o_bw_rate,
    output logic [DATA_W-1:0]   o_power_ctl,
    output logic [DATA_W-1:0]   o_data_format,
    output logic                o_wr_strobe,
    output logic [ADDR_W-1:0]   o_wr_addr,
    output logic [DATA_W-1:0]   o_wr_data
);

    logic cs_level_unused, cs_rise, cs_fall;
    logic spc_level_unused, spc_rise, spc_fall;
    logic sdi_q, sdi_rise_unused, sdi_fall_unused;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk(i_clk), .rst(i_rst), .din(i_CS),
        .level(cs_level_unused), .rise_c(cs_rise), .fall_c(cs_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_spc (
        .clk(i_clk), .rst(i_rst), .din(i_SPC),
        .level(spc_level_unused), .rise_c(spc_rise), .fall_c(spc_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdi (
        .clk(i_clk), .rst(i_rst), .din(i_SDI),
        .level(sdi_q), .rise_c(sdi_rise_unused), .fall_c(sdi_fall_unused)
    );

    spi_state_e           state;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [ADDR_W-1:0]    addr;
    logic                 mb;
    logic [DATA_W-1:0]    shreg;
    logic [SNAP_W-1:0]    snap;

    logic [DATA_W-1:0]    rd_val_c;
    logic [DATA_W-1:0]    in_byte_c;
    logic [ADDR_W-1:0]    next_addr_c;
    logic                 last_bit_c;

    // Read map; axis bytes come from the snapshot, little-endian per axis.
    always_comb begin
        rd_val_c = '0;
        case (addr)
            ADDR_DEVID:       rd_val_c = DEVID_VAL;
            ADDR_BW_RATE:     rd_val_c = o_bw_rate;
            ADDR_POWER_CTL:   rd_val_c = o_power_ctl;
            ADDR_DATA_FORMAT: rd_val_c = o_data_format;
            ADDR_DATAX0:      rd_val_c = snap[7:0];
            ADDR_DATAX1:      rd_val_c = snap[15:8];
            ADDR_DATAY0:      rd_val_c = snap[23:16];
            ADDR_DATAY1:      rd_val_c = snap[31:24];
            ADDR_DATAZ0:      rd_val_c = snap[39:32];
            ADDR_DATAZ1:      rd_val_c = snap[47:40];
            default:          rd_val_c = '0;
        endcase
    end

    assign in_byte_c   = {shreg[DATA_W-2:0], sdi_q};
    assign next_addr_c = mb ? ADDR_W'(addr + 6'd1) : addr;
    assign last_bit_c  = (bit_cnt == 3'd7);

    // Transfer FSM with shift register, register file and snapshot.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state         <= ST_IDLE;
            bit_cnt       <= '0;
            addr          <= '0;
            mb            <= 1'b0;
            shreg         <= '0;
            snap          <= '0;
            o_SDO         <= 1'b0;
            o_SDO_oe      <= 1'b0;
            o_bw_rate     <= RST_BW_RATE;
            o_power_ctl   <= RST_POWER_CTL;
            o_data_format <= RST_DATA_FORMAT;
            o_wr_strobe   <= 1'b0;
            o_wr_addr     <= '0;
            o_wr_data     <= '0;
        end else begin
            o_wr_strobe <= 1'b0;
            if (cs_rise) begin
                // Deselect aborts any partial byte without side effects.
                state    <= ST_IDLE;
                o_SDO_oe <= 1'b0;
                o_SDO    <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (cs_fall) begin
                            state    <= ST_CMD;
                            o_SDO_oe <= 1'b1;
                            o_SDO    <= 1'b0;
                            bit_cnt  <= '0;
                            snap     <= {i_az, i_ay, i_ax};
                        end
                    end
                    ST_CMD: begin
                        o_SDO <= 1'b0;
                        if (spc_rise) begin
                            shreg   <= in_byte_c;
                            bit_cnt <= BIT_CNT_W'(bit_cnt + 3'd1);
                            if (last_bit_c) begin
                                // in_byte_c = {R/W, MB, addr[5:0]}
                                addr  <= in_byte_c[5:0];
                                mb    <= in_byte_c[6];
                                state <= in_byte_c[7] ? ST_RDATA : ST_WDATA;
                            end
                        end
                    end
                    ST_RDATA: begin
                        if (spc_fall) begin
                            if (bit_cnt == 3'd0) begin
                                o_SDO <= rd_val_c[7];
                                shreg <= {rd_val_c[6:0], 1'b0};
                            end else begin
                                o_SDO <= shreg[7];
                                shreg <= {shreg[6:0], 1'b0};
                            end
                        end
                        if (spc_rise) begin
                            bit_cnt <= BIT_CNT_W'(bit_cnt + 3'd1);
                            if (last_bit_c) begin
                                addr <= next_addr_c;
                            end
                        end
                    end
                    ST_WDATA: begin
                        o_SDO <= 1'b0;
                        if (spc_rise) begin
                            shreg   <= in_byte_c;
                            bit_cnt <= BIT_CNT_W'(bit_cnt + 3'd1);
                            if (last_bit_c) begin
                                if (is_writable(addr)) begin
                                    case (addr)
                                        ADDR_BW_RATE:   o_bw_rate     <= in_byte_c;
                                        ADDR_POWER_CTL: o_power_ctl   <= in_byte_c;
                                        default:        o_data_format <= in_byte_c;
                                    endcase
                                    o_wr_strobe <= 1'b1;
                                    o_wr_addr   <= addr;
                                    o_wr_data   <= in_byte_c;
                                end
                                addr <= next_addr_c;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_adxl345_spi_responder.sv
// Self-checking bench: directed scenarios plus randomized reads/writes
// compared against a register-map level reference model.
module tb_adxl345_spi_responder;

    localparam int HALF = 6;   // SPC half period in i_clk cycles

    logic        clk = 1'b0;
    logic        rst, cs, spc, sdi;
    logic        sdo, sdo_oe;
    logic [15:0] ax, ay, az;
    logic [7:0]  bw_rate, power_ctl, data_format;
    logic        wr_strobe;
    logic [5:0]  wr_addr;
    logic [7:0]  wr_data;

    adxl345_spi_responder dut (
        .i_clk(clk), .i_rst(rst), .i_CS(cs), .i_SPC(spc), .i_SDI(sdi),
        .o_SDO(sdo), .o_SDO_oe(sdo_oe),
        .i_ax(ax), .i_ay(ay), .i_az(az),
        .o_bw_rate(bw_rate), .o_power_ctl(power_ctl), .o_data_format(data_format),
        .o_wr_strobe(wr_strobe), .o_wr_addr(wr_addr), .o_wr_data(wr_data)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int strobe_cnt = 0;

    always @(posedge clk) if (wr_strobe === 1'b1) strobe_cnt <= strobe_cnt + 1;

    // Reference model state
    logic [7:0]  m_bw = 8'h0A, m_pc = 8'h00, m_df = 8'h00;
    logic [15:0] m_sx, m_sy, m_sz;
    int          exp_strobes = 0;
    logic [5:0]  exp_waddr = 6'h00;
    logic [7:0]  exp_wdata = 8'h00;

    function automatic logic [7:0] model_byte(input logic [5:0] a);
        if (a == 6'h00) return 8'hE5;
        if (a == 6'h2C) return m_bw;
        if (a == 6'h2D) return m_pc;
        if (a == 6'h31) return m_df;
        if (a >= 6'h32 && a <= 6'h37) begin
            logic [47:0] s;
            int k;
            s = {m_sz, m_sy, m_sx};
            k = int'(a) - 'h32;
            return s[8*k +: 8];
        end
        return 8'h00;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cs_low();
        cs = 1'b0;
        m_sx = ax; m_sy = ay; m_sz = az;
        clks(HALF);
    endtask

    task automatic cs_high();
        clks(HALF);
        cs = 1'b1;
        clks(HALF + 2);
    endtask

    // Transfer nbits MSB first; rx collects SDO sampled just before each rise.
    task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            spc = 1'b0;
            sdi = tx[7-i];
            clks(HALF);
            rx = {rx[6:0], sdo};
            spc = 1'b1;
            clks(HALF);
        end
    endtask

    task automatic do_read(input logic [5:0] a, input bit mb, input int n, input bit disturb);
        logic [7:0] rx;
        logic [5:0] cur;
        cur = a;
        cs_low();
        check("oe_cs_low", 16'(sdo_oe), 16'h1);
        xfer({1'b1, mb, a}, 8, rx);
        check("sdo_in_cmd", 16'(rx), 16'h0);
        if (disturb) ax = ~ax;
        for (int i = 0; i < n; i++) begin
            xfer(8'hFF, 8, rx);
            check($sformatf("rd_a%0h", cur), 16'(rx), 16'(model_byte(cur)));
            if (mb) cur = cur + 6'd1;
        end
        cs_high();
        check("oe_cs_high", 16'(sdo_oe), 16'h0);
        check("sdo_cs_high", 16'(sdo), 16'h0);
    endtask

    task automatic check_regs(input string tag);
        check({tag, "_bw"}, 16'(bw_rate), 16'(m_bw));
        check({tag, "_pc"}, 16'(power_ctl), 16'(m_pc));
        check({tag, "_df"}, 16'(data_format), 16'(m_df));
        check({tag, "_nstb"}, 16'(strobe_cnt), 16'(exp_strobes));
        check({tag, "_waddr"}, 16'(wr_addr), 16'(exp_waddr));
        check({tag, "_wdata"}, 16'(wr_data), 16'(exp_wdata));
    endtask

    // Writes n bytes taken low byte first from d; model applies spec write rules.
    task automatic do_write(input logic [5:0] a, input bit mb, input int n, input logic [31:0] d);
        logic [7:0] rx, b;
        logic [5:0] cur;
        cur = a;
        cs_low();
        xfer({1'b0, mb, a}, 8, rx);
        for (int i = 0; i < n; i++) begin
            b = d[8*i +: 8];
            xfer(b, 8, rx);
            if (cur == 6'h2C || cur == 6'h2D || cur == 6'h31) begin
                if (cur == 6'h2C) m_bw = b;
                else if (cur == 6'h2D) m_pc = b;
                else m_df = b;
                exp_strobes++;
                exp_waddr = cur;
                exp_wdata = b;
            end
            if (mb) cur = cur + 6'd1;
        end
        cs_high();
        check_regs("wr");
    endtask

    initial begin
        logic [7:0] rx;
        logic [5:0] pool [5];
        rst = 1'b1; cs = 1'b1; spc = 1'b1; sdi = 1'b0;
        ax = 16'h0; ay = 16'h0; az = 16'h0;
        clks(5);
        rst = 1'b0;
        clks(4);

        // Reset state
        check("rst_sdo", 16'(sdo), 16'h0);
        check("rst_oe", 16'(sdo_oe), 16'h0);
        check("rst_strobe", 16'(wr_strobe), 16'h0);
        check_regs("rst");

        // DEVID read
        do_read(6'h00, 1'b0, 1, 1'b0);

        // Axis burst read, ax changed after CS fall must not show
        ax = 16'h0123; ay = 16'hFFFE; az = 16'h0100;
        do_read(6'h32, 1'b1, 6, 1'b1);
        check("bytes_x0_const", 16'(m_sx[7:0]), 16'h23);

        // Writable register write and read-back
        do_write(6'h2D, 1'b0, 1, 32'h08);
        check("pc_08", 16'(power_ctl), 16'h08);
        do_read(6'h2D, 1'b0, 1, 1'b0);

        // Write to read-only address, then MB wrap read 0x3F -> 0x00
        do_write(6'h00, 1'b0, 1, 32'h55);
        do_read(6'h3F, 1'b1, 2, 1'b0);

        // Partial write to DATA_FORMAT aborted by CS rise
        cs_low();
        xfer(8'h31, 8, rx);
        xfer(8'hA7, 5, rx);
        cs_high();
        check_regs("partial");
        do_read(6'h00, 1'b0, 1, 1'b0);

        // Randomized traffic against the model
        pool[0] = 6'h00; pool[1] = 6'h2C; pool[2] = 6'h2D; pool[3] = 6'h31; pool[4] = 6'h10;
        for (int it = 0; it < 24; it++) begin
            int op;
            logic [5:0] a;
            op = $urandom_range(0, 2);
            ax = 16'($urandom); ay = 16'($urandom); az = 16'($urandom);
            if (op == 0) begin
                do_read(6'($urandom_range(6'h30, 6'h37)), 1'b1, $urandom_range(1, 6), 1'($urandom));
            end else begin
                a = pool[$urandom_range(0, 4)];
                if ($urandom_range(0, 4) == 0) a = 6'($urandom);
                if (op == 1) do_write(a, 1'($urandom), $urandom_range(1, 3), $urandom);
                else do_read(a, 1'($urandom), $urandom_range(1, 3), 1'b0);
            end
        end

        // Reset in the middle of a read data byte
        do_write(6'h2C, 1'b0, 1, 32'h0F);
        cs_low();
        xfer(8'hB2, 8, rx);
        xfer(8'hFF, 3, rx);
        spc = 1'b0;
        clks(HALF);
        rst = 1'b1;
        clks(1);
        m_bw = 8'h0A; m_pc = 8'h00; m_df = 8'h00;
        exp_waddr = 6'h00; exp_wdata = 8'h00;
        check("midrst_sdo", 16'(sdo), 16'h0);
        check("midrst_oe", 16'(sdo_oe), 16'h0);
        check("midrst_strobe", 16'(wr_strobe), 16'h0);
        check_regs("midrst");
        cs = 1'b1; spc = 1'b1;
        clks(4);
        rst = 1'b0;
        clks(4);
        do_read(6'h2C, 1'b0, 1, 1'b0);
        do_read(6'h00, 1'b0, 1, 1'b0);
        do_write(6'h31, 1'b0, 1, 32'h0B);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
